apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
APB initiator (requester side) that turns a simple valid/ready command into one APB transfer and returns the result on a valid/ready response channel. It drives the master-facing signal set of the team's APB interface (PSEL, PENABLE, PWRITE, PADDR, PWDATA). It consumes PRDATA, PREADY and PSLVERR. It sits between an internal controller (test sequencer or CPU-side logic) and any APB completer built on the slave-side signal set.

Parameters:
- ADDR_W, 32, width of PADDR and cmd_addr
- DATA_W, 32, width of PWDATA/PRDATA and the command/response data
- TIMEOUT_CYCLES, 16, wait-state limit in ACCESS; used only when APB_MASTER_TIMEOUT_EN is defined; must be >= 1

Ports:
- PCLK in 1: clock, all flops rising-edge
- PRESETn in 1: asynchronous active-low reset
- cmd_valid in 1: command request
- cmd_ready out 1: bridge can accept a command
- cmd_write in 1: 1 = write, 0 = read
- cmd_addr in ADDR_W: transfer address
- cmd_wdata in DATA_W: write data
- rsp_valid out 1: response available
- rsp_ready in 1: consumer takes the response
- rsp_rdata out DATA_W: read data; 0 for writes
- rsp_err out 1: PSLVERR, or timeout abort when the macro is defined
- PSEL out 1, PENABLE out 1, PWRITE out 1: APB control
- PADDR out ADDR_W, PWDATA out DATA_W: APB address and write data
- PRDATA in DATA_W, PREADY in 1, PSLVERR in 1: completer response

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from state only; no comb path from APB inputs to APB outputs.
- Reset (PRESETn low, acts immediately, including mid-transfer):
  - state = IDLE
  - PSEL = PENABLE = PWRITE = 0; PADDR = PWDATA = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - cmd_ready = 1 after reset is released
  - Any in-flight transfer is dropped with no response.
- IDLE:
  - cmd_ready = 1, PSEL = 0, PENABLE = 0.
  - On cmd_valid & cmd_ready: latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, go to SETUP.
- SETUP: exactly one cycle with PSEL = 1, PENABLE = 0; cmd_ready = 0; then go to ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1.
  - PREADY = 0: stay (wait state).
  - PREADY = 1: capture rsp_err = PSLVERR and rsp_rdata = PWRITE ? 0 : PRDATA; go to RESP.
  - PRDATA and PSLVERR are ignored in every other state and cycle.
- RESP:
  - PSEL = PENABLE = 0, rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then go to IDLE.
  - cmd_ready = 0 in RESP, so exactly one transfer is outstanding.
- Stability: PADDR, PWRITE and PWDATA are unchanged from SETUP through the last ACCESS cycle, and held afterwards until the next command is accepted.
- Latency:
  - Command accepted at edge N: SETUP in cycle N+1, ACCESS in cycle N+2.
  - With zero wait states, rsp_valid = 1 in cycle N+3.
  - Each PREADY-low cycle adds 1.
  - The next command can be accepted no earlier than the cycle after the response handshake.
- Simultaneous events: cmd_valid while not IDLE is ignored; the command is not consumed.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES while PREADY is still 0: abort to RESP with rsp_err = 1, rsp_rdata = 0, and PSEL/PENABLE dropped the next cycle.
  - PREADY = 1 in the same cycle as the limit is reached wins: this is a normal completion.
- Not defined: no counter; ACCESS waits indefinitely for PREADY; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum type (IDLE, SETUP, ACCESS, RESP)
  - default ADDR_W/DATA_W constants
  - a packed response struct (rdata, err)
- No sub-module is needed. The timeout counter stays inline under the macro guard.

Test Plan:
- Zero-wait write: cmd write addr 0x0000_0010 data 0xDEAD_BEEF, PREADY = 1 -> PSEL rises at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: read addr 0x24, PREADY low 3 cycles then high with PRDATA = 0x1234_5678 -> rsp_valid at N+6, rsp_rdata = 0x1234_5678; PADDR stable throughout.
- Slave error: read, PREADY = 1 with PSLVERR = 1 -> rsp_err = 1; a second command is blocked (cmd_ready = 0) until rsp_ready = 1.
- Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, PSEL = 0, cmd_ready = 0; accept occurs the cycle after rsp_ready = 1.
- Reset mid-ACCESS: PRESETn low during a wait state -> PSEL/PENABLE/rsp_valid go to 0 immediately, no response; after release cmd_ready = 1.
- Timeout (macro defined, TIMEOUT_CYCLES = 4): PREADY held 0 -> abort after 4 wait cycles, rsp_err = 1, rsp_rdata = 0. Without the macro, the same stimulus stays in ACCESS indefinitely.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types: bridge FSM states, default bus widths and the response record.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB signal bundle; master drives control/address/write data, slave drives the response.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: one valid/ready command becomes one APB transfer, result returned on a
// valid/ready response channel. Optional ACCESS wait-state timeout: APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  apb_master_bridge_if.master apb
);

  if (TIMEOUT_CYCLES == 0) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e        state_q, state_d;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = (state_q == StIdle) && cmd_valid;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q;
  logic            tmo_hit;

  // Abort only when the limit is reached and the completer is still stalling.
  assign tmo_hit = (state_q == StAccess) && !apb.PREADY &&
                   (wait_cnt_q == CntW'(TIMEOUT_CYCLES));

  // Wait-state counter: cleared in SETUP so it starts at zero on ACCESS entry.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else if (state_q == StSetup) begin
      wait_cnt_q <= '0;
    end else if ((state_q == StAccess) && !apb.PREADY && !tmo_hit) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`endif

  // Next-state and response capture; APB inputs are only looked at in ACCESS.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = StSetup;
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (apb.PREADY) begin
          state_d = StResp;
          err_d   = apb.PSLVERR;
          rdata_d = pwrite_q ? '0 : apb.PRDATA;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = '0;
        end
`endif
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and response registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Command latch: held from SETUP until the next accepted command.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      pwrite_q <= cmd_write;
      paddr_q  <= cmd_addr;
      pwdata_q <= cmd_wdata;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign apb.PSEL    = (state_q == StSetup) || (state_q == StAccess);
  assign apb.PENABLE = (state_q == StAccess);
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; completer side driven directly from the stimulus.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  apb_master_bridge #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .apb      (apb)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Present a command for one edge (edge N); returns in cycle N+1.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("hs_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    apb.PRDATA  = 32'hA5A5_A5A5;
    apb.PREADY  = 1'b1;
    apb.PSLVERR = 1'b0;
    #22;
    check("rst_psel", {31'b0, apb.PSEL}, 32'd0);
    check("rst_penable", {31'b0, apb.PENABLE}, 32'd0);
    check("rst_pwrite", {31'b0, apb.PWRITE}, 32'd0);
    check("rst_paddr", apb.PADDR, 32'd0);
    check("rst_pwdata", apb.PWDATA, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Zero-wait write; PRDATA junk must not leak into rsp_rdata.
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("wr_setup_psel", {31'b0, apb.PSEL}, 32'd1);
    check("wr_setup_penable", {31'b0, apb.PENABLE}, 32'd0);
    check("wr_setup_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("wr_pwrite", {31'b0, apb.PWRITE}, 32'd1);
    check("wr_paddr", apb.PADDR, 32'h0000_0010);
    check("wr_pwdata", apb.PWDATA, 32'hDEAD_BEEF);
    tick();
    check("wr_access_psel", {31'b0, apb.PSEL}, 32'd1);
    check("wr_access_penable", {31'b0, apb.PENABLE}, 32'd1);
    check("wr_access_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("wr_rsp_psel", {31'b0, apb.PSEL}, 32'd0);
    check("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    handshake();
    check("wr_paddr_held", apb.PADDR, 32'h0000_0010);

    // Read with 3 wait states.
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'hFFFF_0000;
    issue(1'b0, 32'h0000_0024, 32'h0);
    check("rd_pwrite", {31'b0, apb.PWRITE}, 32'd0);
    check("rd_paddr_setup", apb.PADDR, 32'h24);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_wait_penable", {31'b0, apb.PENABLE}, 32'd1);
      check("rd_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rd_wait_paddr", apb.PADDR, 32'h24);
    end
    tick();
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'h1234_5678;
    check("rd_last_penable", {31'b0, apb.PENABLE}, 32'd1);
    check("rd_last_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    apb.PRDATA = 32'hCAFE_CAFE;
    check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_rsp_err", {31'b0, rsp_err}, 32'd0);
    handshake();

    // Slave error, then 5 cycles of response backpressure with a pending command.
    apb.PSLVERR = 1'b1;
    apb.PRDATA  = 32'h55AA_55AA;
    issue(1'b0, 32'h0000_0030, 32'h0);
    tick();
    tick();
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = 32'h0F0F_0F0F;
    cmd_write   = 1'b1;
    cmd_addr    = 32'h0000_0040;
    cmd_wdata   = 32'h0BAD_F00D;
    cmd_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_err", {31'b0, rsp_err}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h55AA_55AA);
      check("bp_psel", {31'b0, apb.PSEL}, 32'd0);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("bp_paddr", apb.PADDR, 32'h30);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp_idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("bp_idle_psel", {31'b0, apb.PSEL}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_psel", {31'b0, apb.PSEL}, 32'd1);
    check("bp_next_paddr", apb.PADDR, 32'h40);
    check("bp_next_pwdata", apb.PWDATA, 32'h0BAD_F00D);
    tick();
    tick();
    check("bp_next_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("bp_next_err", {31'b0, rsp_err}, 32'd0);
    check("bp_next_rdata", rsp_rdata, 32'd0);
    handshake();

    // Reset in the middle of a wait state.
    apb.PREADY = 1'b0;
    issue(1'b0, 32'h0000_0050, 32'h0);
    tick();
    check("mr_penable", {31'b0, apb.PENABLE}, 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("mr_psel", {31'b0, apb.PSEL}, 32'd0);
    check("mr_penable_low", {31'b0, apb.PENABLE}, 32'd0);
    check("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mr_paddr", apb.PADDR, 32'd0);
    tick();
    @(negedge PCLK);
    PRESETn    = 1'b1;
    apb.PREADY = 1'b1;
    tick();
    check("mr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("mr_rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    check("mr_psel_after", {31'b0, apb.PSEL}, 32'd0);

    // Completer never ready.
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'h6666_6666;
    issue(1'b0, 32'h0000_0060, 32'h0);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      tick();
      check("to_wait_penable", {31'b0, apb.PENABLE}, 32'd1);
      check("to_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    tick();
    check("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'b0, rsp_err}, 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    check("to_psel", {31'b0, apb.PSEL}, 32'd0);
    apb.PREADY = 1'b1;
    handshake();
`else
    for (int i = 0; i < 20; i++) tick();
    check("nto_penable", {31'b0, apb.PENABLE}, 32'd1);
    check("nto_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'h0000_0077;
    tick();
    check("nto_rsp_valid_done", {31'b0, rsp_valid}, 32'd1);
    check("nto_rsp_rdata", rsp_rdata, 32'h77);
    check("nto_rsp_err", {31'b0, rsp_err}, 32'd0);
    handshake();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
